cci_resp_emulator: RTL and testbench

CCI_RESP_EMULATOR -- requirements
Module: cci_resp_emulator

---
 rtl/ase_cci_pkg.sv | 24 ++
 rtl/cci_resp_emulator_if.sv | 33 +++
 rtl/ase_resp_fifo.sv | 73 +++++++
 rtl/cci_resp_emulator.sv | 79 +++++++
 tb/tb_cci_resp_emulator.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ase_cci_pkg.sv
// Shared CCI field positions, response opcodes and the per-entry record used by
// the response emulator's queues.
package ase_cci_pkg;

  localparam int TX_MDATA_BITRANGE_HI  = 13;
  localparam int TX_MDATA_BITRANGE_LO  = 0;
  localparam int TX_CLADDR_BITRANGE_HI = 45;
  localparam int TX_CLADDR_BITRANGE_LO = 14;
  localparam int RX_MDATA_BITRANGE_HI  = 13;
  localparam int RX_MDATA_BITRANGE_LO  = 0;

  localparam int MDATA_W  = TX_MDATA_BITRANGE_HI - TX_MDATA_BITRANGE_LO + 1;
  localparam int CLADDR_W = TX_CLADDR_BITRANGE_HI - TX_CLADDR_BITRANGE_LO + 1;

  localparam logic [3:0] RSP_RD = 4'h4;
  localparam logic [3:0] RSP_WR = 4'h1;

  typedef struct packed {
    logic [MDATA_W-1:0]  mdata;
    logic [CLADDR_W-1:0] claddr;
    logic [7:0]          age;
  } resp_entry_t;

endpackage

// File: rtl/cci_resp_emulator_if.sv
// CCI request/response bundle between a requester (master) and the emulator (slave).
// A request is taken on every rising edge its valid is high; almostfull is advisory
// backpressure with no ready, and each response valid is a one-cycle pulse.
interface cci_resp_emulator_if #(
  parameter int TX_HDR_WIDTH = 61,
  parameter int RX_HDR_WIDTH = 18,
  parameter int DATA_WIDTH   = 512
);
  logic [TX_HDR_WIDTH-1:0] tx_c0_header;
  logic                    tx_c0_rdvalid;
  logic [TX_HDR_WIDTH-1:0] tx_c1_header;
  logic                    tx_c1_wrvalid;
  logic                    tx_c0_almostfull;
  logic                    tx_c1_almostfull;
  logic [RX_HDR_WIDTH-1:0] rx_c0_header;
  logic [DATA_WIDTH-1:0]   rx_c0_data;
  logic                    rx_c0_rdvalid;
  logic [RX_HDR_WIDTH-1:0] rx_c1_header;
  logic                    rx_c1_wrvalid;
  logic                    ovf_err;

  modport master (
    output tx_c0_header, tx_c0_rdvalid, tx_c1_header, tx_c1_wrvalid,
    input  tx_c0_almostfull, tx_c1_almostfull, rx_c0_header, rx_c0_data,
    input  rx_c0_rdvalid, rx_c1_header, rx_c1_wrvalid, ovf_err
  );

  modport slave (
    input  tx_c0_header, tx_c0_rdvalid, tx_c1_header, tx_c1_wrvalid,
    output tx_c0_almostfull, tx_c1_almostfull, rx_c0_header, rx_c0_data,
    output rx_c0_rdvalid, rx_c1_header, rx_c1_wrvalid, ovf_err
  );
endinterface

// File: rtl/ase_resp_fifo.sv
// In-order request queue for one channel: each entry ages one per cycle and the
// head retires once it has waited LATENCY cycles.
module ase_resp_fifo
  import ase_cci_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [MDATA_W-1:0]  push_mdata,
  input  logic [CLADDR_W-1:0] push_claddr,
  output logic                pop,
  output logic [MDATA_W-1:0]  head_mdata,
  output logic [CLADDR_W-1:0] head_claddr,
  output logic                almostfull,
  output logic                ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0]    LAT     = 8'(LATENCY);
  localparam logic [CW-1:0] FULL_N  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_N = CW'(DEPTH - 2);

  resp_entry_t       mem [DEPTH];
  logic [DEPTH-1:0]  occ;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              full;
  logic              push_ok;

  assign full        = (count == FULL_N);
  assign pop         = occ[rd_ptr] && (mem[rd_ptr].age == LAT);
  // A retiring head frees its slot in the same cycle, so a full queue still takes a push.
  assign push_ok     = push && (!full || pop);
  assign count_next  = count + CW'(push_ok) - CW'(pop);
  assign head_mdata  = mem[rd_ptr].mdata;
  assign head_claddr = mem[rd_ptr].claddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      almostfull <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occ[i] && (mem[i].age != LAT)) mem[i].age <= mem[i].age + 8'd1;
      end
      if (pop) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      // Placed after the pop so a slot freed and refilled this cycle stays occupied.
      if (push_ok) begin
        mem[wr_ptr] <= '{mdata: push_mdata, claddr: push_claddr, age: 8'd1};
        occ[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      count      <= count_next;
      almostfull <= (count_next >= AFULL_N);
      if (push && !push_ok) ovf_err <= 1'b1;
    end
  end

endmodule

// File: rtl/cci_resp_emulator.sv
// Emulates CCI read/write completions: requests are queued per channel and
// answered LATENCY cycles later with registered headers and read data.
module cci_resp_emulator
  import ase_cci_pkg::*;
#(
  parameter int TX_HDR_WIDTH = 61,
  parameter int RX_HDR_WIDTH = 18,
  parameter int DATA_WIDTH   = 512,
  parameter int DEPTH        = 8,
  parameter int LATENCY      = 4
) (
  input logic                clk,
  input logic                rst,
  cci_resp_emulator_if.slave bus
);

  logic                c0_pop;
  logic                c1_pop;
  logic [MDATA_W-1:0]  c0_mdata;
  logic [MDATA_W-1:0]  c1_mdata;
  logic [CLADDR_W-1:0] c0_claddr;
  logic [CLADDR_W-1:0] c1_claddr_unused;
  logic                c0_ovf;
  logic                c1_ovf;
  logic                unused_tx_bits;

  // Header bits above the address field carry request type and are ignored here.
  assign unused_tx_bits = ^{bus.tx_c0_header[TX_HDR_WIDTH-1:TX_CLADDR_BITRANGE_HI+1],
                            bus.tx_c1_header[TX_HDR_WIDTH-1:TX_CLADDR_BITRANGE_HI+1],
                            c1_claddr_unused};

  ase_resp_fifo #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_c0_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (bus.tx_c0_rdvalid),
    .push_mdata  (bus.tx_c0_header[TX_MDATA_BITRANGE_HI:TX_MDATA_BITRANGE_LO]),
    .push_claddr (bus.tx_c0_header[TX_CLADDR_BITRANGE_HI:TX_CLADDR_BITRANGE_LO]),
    .pop         (c0_pop),
    .head_mdata  (c0_mdata),
    .head_claddr (c0_claddr),
    .almostfull  (bus.tx_c0_almostfull),
    .ovf_err     (c0_ovf)
  );

  ase_resp_fifo #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_c1_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (bus.tx_c1_wrvalid),
    .push_mdata  (bus.tx_c1_header[TX_MDATA_BITRANGE_HI:TX_MDATA_BITRANGE_LO]),
    .push_claddr (bus.tx_c1_header[TX_CLADDR_BITRANGE_HI:TX_CLADDR_BITRANGE_LO]),
    .pop         (c1_pop),
    .head_mdata  (c1_mdata),
    .head_claddr (c1_claddr_unused),
    .almostfull  (bus.tx_c1_almostfull),
    .ovf_err     (c1_ovf)
  );

  assign bus.ovf_err = c0_ovf | c1_ovf;

  // Header and data hold their last value between responses; only the valids pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_c0_header  <= '0;
      bus.rx_c0_data    <= '0;
      bus.rx_c0_rdvalid <= 1'b0;
      bus.rx_c1_header  <= '0;
      bus.rx_c1_wrvalid <= 1'b0;
    end else begin
      bus.rx_c0_rdvalid <= c0_pop;
      bus.rx_c1_wrvalid <= c1_pop;
      if (c0_pop) begin
        bus.rx_c0_header <= RX_HDR_WIDTH'({RSP_RD, c0_mdata});
        bus.rx_c0_data   <= {(DATA_WIDTH/64){{(64-CLADDR_W)'(0), c0_claddr}}};
      end
      if (c1_pop) bus.rx_c1_header <= RX_HDR_WIDTH'({RSP_WR, c1_mdata});
    end
  end

endmodule

// File: tb/tb_cci_resp_emulator.sv
// Directed bench for cci_resp_emulator: one instance at LATENCY 4 for timing and
// reset behaviour, one at LATENCY 12 so the queue can fill before anything retires.
module tb_cci_resp_emulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cci_resp_emulator_if #(.TX_HDR_WIDTH(61), .RX_HDR_WIDTH(18), .DATA_WIDTH(512)) a_if ();
  cci_resp_emulator_if #(.TX_HDR_WIDTH(61), .RX_HDR_WIDTH(18), .DATA_WIDTH(512)) b_if ();

  cci_resp_emulator #(.DEPTH(8), .LATENCY(4)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
  cci_resp_emulator #(.DEPTH(8), .LATENCY(12)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int checks = 0;
  int failures = 0;
  logic [45:0] exp_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [60:0] hdr(input logic [13:0] md, input logic [31:0] addr);
    return {15'd0, addr, md};
  endfunction

  function automatic logic [511:0] line(input logic [31:0] addr);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = {32'd0, addr};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drains channel-0 responses of instance b against exp_q, checking arrival edges.
  task automatic collect_b(input int first_e, input int last_e, input int late_edge,
                           output int resp);
    logic [45:0] e_item;
    int exp_e;
    resp = 0;
    for (int e = first_e; e <= last_e; e++) begin
      tick();
      if (e == first_e) b_if.tx_c0_rdvalid = 1'b0;
      if (e == 14) chk("b_af_count6", 512'(b_if.tx_c0_almostfull), 512'(1));
      if (b_if.rx_c0_rdvalid) begin
        resp++;
        exp_e = (resp <= 8) ? 12 + resp : late_edge;
        chk("b_resp_edge", 512'(e), 512'(exp_e));
        if (exp_q.size() == 0) begin
          chk("b_extra_resp", 512'(resp), 512'(0));
        end else begin
          e_item = exp_q.pop_front();
          chk("b_hdr", 512'(b_if.rx_c0_header), 512'({4'h4, e_item[13:0]}));
          chk("b_data", b_if.rx_c0_data, line(e_item[45:14]));
        end
      end
    end
  endtask

  initial begin
    int n;
    a_if.tx_c0_header = '0; a_if.tx_c0_rdvalid = 1'b0;
    a_if.tx_c1_header = '0; a_if.tx_c1_wrvalid = 1'b0;
    b_if.tx_c0_header = '0; b_if.tx_c0_rdvalid = 1'b0;
    b_if.tx_c1_header = '0; b_if.tx_c1_wrvalid = 1'b0;

    // Reset state
    #2;
    chk("rst_a_rdvalid", 512'(a_if.rx_c0_rdvalid), 512'(0));
    chk("rst_a_wrvalid", 512'(a_if.rx_c1_wrvalid), 512'(0));
    chk("rst_a_af0", 512'(a_if.tx_c0_almostfull), 512'(0));
    chk("rst_a_af1", 512'(a_if.tx_c1_almostfull), 512'(0));
    chk("rst_a_ovf", 512'(a_if.ovf_err), 512'(0));
    chk("rst_a_hdr0", 512'(a_if.rx_c0_header), 512'(0));
    chk("rst_a_hdr1", 512'(a_if.rx_c1_header), 512'(0));
    chk("rst_a_data", a_if.rx_c0_data, 512'(0));
    chk("rst_b_ovf", 512'(b_if.ovf_err), 512'(0));
    tick();
    tick();
    rst = 1'b0;

    // Single read on the first edge after reset release, LATENCY 4
    a_if.tx_c0_header = hdr(14'h12, 32'h100);
    a_if.tx_c0_rdvalid = 1'b1;
    tick();
    a_if.tx_c0_rdvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("a_early_rdvalid", 512'(a_if.rx_c0_rdvalid), 512'(0));
    end
    tick();
    chk("a_rdvalid_at_lat", 512'(a_if.rx_c0_rdvalid), 512'(1));
    chk("a_rd_hdr", 512'(a_if.rx_c0_header), 512'(18'h10012));
    chk("a_rd_data", a_if.rx_c0_data, line(32'h100));
    tick();
    chk("a_rdvalid_pulse", 512'(a_if.rx_c0_rdvalid), 512'(0));
    chk("a_rd_hdr_hold", 512'(a_if.rx_c0_header), 512'(18'h10012));

    // Read and write in the same cycle
    a_if.tx_c0_header = hdr(14'h3A, 32'h2000);
    a_if.tx_c0_rdvalid = 1'b1;
    a_if.tx_c1_header = hdr(14'h155, 32'h77);
    a_if.tx_c1_wrvalid = 1'b1;
    tick();
    a_if.tx_c0_rdvalid = 1'b0;
    a_if.tx_c1_wrvalid = 1'b0;
    tick(); tick(); tick();
    chk("a_wr_early", 512'(a_if.rx_c1_wrvalid), 512'(0));
    tick();
    chk("a_both_rdvalid", 512'(a_if.rx_c0_rdvalid), 512'(1));
    chk("a_both_wrvalid", 512'(a_if.rx_c1_wrvalid), 512'(1));
    chk("a_both_rd_hdr", 512'(a_if.rx_c0_header), 512'(18'h1003A));
    chk("a_both_wr_hdr", 512'(a_if.rx_c1_header), 512'(18'h04155));
    chk("a_both_data", a_if.rx_c0_data, line(32'h2000));
    tick();
    chk("a_wr_pulse", 512'(a_if.rx_c1_wrvalid), 512'(0));
    chk("a_wr_hdr_hold", 512'(a_if.rx_c1_header), 512'(18'h04155));

    // Reset with three reads still in flight while a response is being presented
    for (int i = 1; i <= 4; i++) begin
      a_if.tx_c0_header = hdr(14'(i), 32'h500 + 32'(i));
      a_if.tx_c0_rdvalid = 1'b1;
      tick();
    end
    a_if.tx_c0_rdvalid = 1'b0;
    tick();
    chk("a_pre_rst_rdvalid", 512'(a_if.rx_c0_rdvalid), 512'(1));
    chk("a_pre_rst_hdr", 512'(a_if.rx_c0_header), 512'(18'h10001));
    #2;
    rst = 1'b1;
    #1;
    chk("a_rst_async_rdvalid", 512'(a_if.rx_c0_rdvalid), 512'(0));
    chk("a_rst_async_hdr", 512'(a_if.rx_c0_header), 512'(0));
    chk("a_rst_async_data", a_if.rx_c0_data, 512'(0));
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (a_if.rx_c0_rdvalid) n++;
    end
    chk("a_no_stale_resp", 512'(n), 512'(0));
    a_if.tx_c0_header = hdr(14'h2A, 32'h3);
    a_if.tx_c0_rdvalid = 1'b1;
    tick();
    a_if.tx_c0_rdvalid = 1'b0;
    tick(); tick(); tick();
    chk("a_post_rst_early", 512'(a_if.rx_c0_rdvalid), 512'(0));
    tick();
    chk("a_post_rst_rdvalid", 512'(a_if.rx_c0_rdvalid), 512'(1));
    chk("a_post_rst_hdr", 512'(a_if.rx_c0_header), 512'(18'h1002A));
    chk("a_post_rst_data", a_if.rx_c0_data, line(32'h3));

    // Nine back-to-back reads into LATENCY 12: eight fill the queue, the ninth drops
    for (int k = 1; k <= 9; k++) begin
      b_if.tx_c0_header = hdr(14'h40 + 14'(k), 32'h1000 + 32'(k));
      b_if.tx_c0_rdvalid = 1'b1;
      if (k <= 8) exp_q.push_back({32'h1000 + 32'(k), 14'h40 + 14'(k)});
      tick();
      chk("b_fill_af", 512'(b_if.tx_c0_almostfull), 512'(k >= 6));
      chk("b_fill_ovf", 512'(b_if.ovf_err), 512'(k == 9));
    end
    collect_b(10, 30, 0, n);
    chk("b_resp_count", 512'(n), 512'(8));
    chk("b_queue_drained", 512'(exp_q.size()), 512'(0));
    chk("b_ovf_sticky", 512'(b_if.ovf_err), 512'(1));
    chk("b_af_drained", 512'(b_if.tx_c0_almostfull), 512'(0));

    // Full queue with a retire and a request on the same edge
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("b_rst_ovf_clear", 512'(b_if.ovf_err), 512'(0));
    for (int k = 1; k <= 8; k++) begin
      b_if.tx_c0_header = hdr(14'h60 + 14'(k), 32'h2000 + 32'(k));
      b_if.tx_c0_rdvalid = 1'b1;
      exp_q.push_back({32'h2000 + 32'(k), 14'h60 + 14'(k)});
      tick();
    end
    b_if.tx_c0_rdvalid = 1'b0;
    for (int k = 9; k <= 12; k++) tick();
    chk("b_full_af", 512'(b_if.tx_c0_almostfull), 512'(1));
    chk("b_full_no_resp_yet", 512'(b_if.rx_c0_rdvalid), 512'(0));
    b_if.tx_c0_header = hdr(14'h7F, 32'h3000);
    b_if.tx_c0_rdvalid = 1'b1;
    exp_q.push_back({32'h3000, 14'h7F});
    collect_b(13, 30, 25, n);
    chk("b_swap_resp_count", 512'(n), 512'(9));
    chk("b_swap_queue_drained", 512'(exp_q.size()), 512'(0));
    chk("b_swap_ovf", 512'(b_if.ovf_err), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
